// File: rtl/systolic_pkg.sv
// Shared constants and the row-collector state type for the systolic array edge FIFOs.
package systolic_pkg;

  localparam int DIM_DEF  = 8;
  localparam int BITS_DEF = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_c.sv
// Serial-to-parallel row collector: gathers DIM serial words into one parallel row.
// Optional sticky overflow flag (ovf port) is built when FIFO_C_OVF_EN is defined.
module fifo_c
  import systolic_pkg::*;
#(
  parameter  int DIM  = DIM_DEF,
  parameter  int BITS = BITS_DEF,
  localparam int CW   = $clog2(DIM + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [BITS-1:0]           d,
  input  logic                      RdEn,
  output logic [DIM-1:0][BITS-1:0]  q,
  output logic                      full,
  output logic [CW-1:0]             count,
`ifdef FIFO_C_OVF_EN
  output logic                      ovf,
`endif
  output state_e                    state_o
);

  // Handshake: en qualifies d for exactly one cycle and there is no back-pressure;
  // words arriving while the row is FULL (and not being released by RdEn the same
  // cycle) are dropped. RdEn only has effect while full=1.

  localparam logic [CW-1:0] DIM_C = CW'(DIM);

  state_e                     state_q, state_d;
  logic [CW-1:0]              count_q, count_d;
  logic [DIM-1:0][BITS-1:0]   row_q,   row_d;
  logic                       wr;
  logic [CW-1:0]              wr_idx;

`ifdef FIFO_C_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_evt;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    row_d   = row_q;
    wr      = 1'b0;
    wr_idx  = count_q;
`ifdef FIFO_C_OVF_EN
    ovf_evt = 1'b0;
`endif

    unique case (state_q)
      EMPTY, FILL: begin
        if (en) begin
          wr      = 1'b1;
          count_d = count_q + CW'(1);
          state_d = (count_d == DIM_C) ? FULL : FILL;
        end
      end
      FULL: begin
        if (en && RdEn) begin
          // Release and restart in one edge: the new word becomes the next row's head.
          wr      = 1'b1;
          wr_idx  = '0;
          count_d = CW'(1);
          state_d = (DIM == 1) ? FULL : FILL;
        end else if (RdEn) begin
          count_d = '0;
          state_d = EMPTY;
        end else if (en) begin
`ifdef FIFO_C_OVF_EN
          ovf_evt = 1'b1;
`endif
        end
      end
      default: begin
        count_d = '0;
        state_d = EMPTY;
      end
    endcase

    if (wr) begin
      for (int i = 0; i < DIM; i++) begin
        if (wr_idx == CW'(i)) row_d[i] = d;
      end
    end

`ifdef FIFO_C_OVF_EN
    ovf_d = ovf_q | ovf_evt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      count_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      row_q   <= row_d;
    end
  end

`ifdef FIFO_C_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign q       = row_q;
  assign full    = (state_q == FULL);
  assign count   = count_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_fifo_c.sv
// Self-checking bench for fifo_c: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue/array level row model.
module tb_fifo_c;
  import systolic_pkg::*;

  localparam int DIM  = 8;
  localparam int BITS = 64;
  localparam int CW   = $clog2(DIM + 1);

  logic                      clk;
  logic                      rst_n;
  logic                      en;
  logic [BITS-1:0]           d;
  logic                      rd;
  logic [DIM-1:0][BITS-1:0]  q;
  logic                      full;
  logic [CW-1:0]             count;
  state_e                    state_o;
`ifdef FIFO_C_OVF_EN
  logic                      ovf;
`endif

  fifo_c #(.DIM(DIM), .BITS(BITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .d       (d),
    .RdEn    (rd),
    .q       (q),
    .full    (full),
    .count   (count),
`ifdef FIFO_C_OVF_EN
    .ovf     (ovf),
`endif
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // ---------------- behavioural model ----------------
  logic [BITS-1:0] m_row [DIM];
  int              m_cnt;
  bit              m_ovf;
  logic [BITS-1:0] exp_q [$];   // words accepted into the row being built

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) m_row[i] = '0;
      m_cnt = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else if (m_cnt == DIM) begin
      if (en && rd) begin
        exp_q.delete();
        exp_q.push_back(d);
        m_row[0] = d;
        m_cnt    = 1;
      end else if (rd) begin
        exp_q.delete();
        m_cnt = 0;
      end else if (en) begin
        m_ovf = 1'b1;
      end
    end else if (en) begin
      exp_q.push_back(d);
      m_row[m_cnt] = d;
      m_cnt        = exp_q.size();
    end
  end

  task automatic cmp(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      state_e s_exp;
      s_exp = (m_cnt == 0) ? EMPTY : (m_cnt == DIM) ? FULL : FILL;
      cmp("count", BITS'(count), BITS'(m_cnt));
      cmp("full", BITS'(full), BITS'(m_cnt == DIM));
      cmp("state", BITS'(state_o), BITS'(s_exp));
      for (int i = 0; i < DIM; i++) cmp($sformatf("q[%0d]", i), q[i], m_row[i]);
      if (m_cnt == DIM)
        for (int i = 0; i < DIM; i++) cmp($sformatf("row_order[%0d]", i), q[i], exp_q[i]);
`ifdef FIFO_C_OVF_EN
      cmp("ovf", BITS'(ovf), BITS'(m_ovf));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; the task returns just after the edge
  // that consumed them, so literal checks see the post-edge values.
  task automatic drive(input logic e, input logic [BITS-1:0] dd, input logic r);
    en = e;
    d  = dd;
    rd = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic check_row_lit(input string name, input int base);
    for (int i = 0; i < DIM; i++) cmp($sformatf("%s q[%0d]", name, i), q[i], BITS'(base + i));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    en = 1'b0; d = '0; rd = 1'b0;
    rst_n = 1'b0;
    #12;
    cmp("rst count", BITS'(count), 0);
    cmp("rst full", BITS'(full), 0);
    for (int i = 0; i < DIM; i++) cmp($sformatf("rst q[%0d]", i), q[i], '0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 1..8
    for (int i = 1; i <= DIM; i++) begin
      drive(1'b1, BITS'(i), 1'b0);
      cmp("fill count", BITS'(count), BITS'(i));
      cmp("fill full", BITS'(full), BITS'(i == DIM));
    end
    check_row_lit("row1", 1);

    // Release without a new word: stale data remains
    drive(1'b0, '0, 1'b1);
    cmp("pop count", BITS'(count), 0);
    cmp("pop full", BITS'(full), 0);
    check_row_lit("stale", 1);

    // Refill 11..18, then release and write simultaneously
    for (int i = 0; i < DIM; i++) drive(1'b1, BITS'(11 + i), 1'b0);
    cmp("row2 full", BITS'(full), 1);
    drive(1'b1, BITS'(99), 1'b1);
    cmp("rw count", BITS'(count), 1);
    cmp("rw full", BITS'(full), 0);
    cmp("rw q0", q[0], BITS'(99));
    cmp("rw state", BITS'(state_o), BITS'(FILL));

    // Complete the row, then overflow
    for (int i = 1; i < DIM; i++) drive(1'b1, BITS'(100 + i), 1'b0);
    drive(1'b1, BITS'(55), 1'b0);
    cmp("ovf count", BITS'(count), BITS'(DIM));
    cmp("ovf q0", q[0], BITS'(99));
    cmp("ovf q7", q[7], BITS'(107));
`ifdef FIFO_C_OVF_EN
    cmp("ovf flag", BITS'(ovf), 1);
`endif
    drive(1'b0, '0, 1'b1);
    cmp("ovf pop count", BITS'(count), 0);
`ifdef FIFO_C_OVF_EN
    cmp("ovf sticky", BITS'(ovf), 1);
`endif

    // Reset mid-fill
    for (int i = 0; i < 3; i++) drive(1'b1, BITS'(40 + i), 1'b0);
    en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    cmp("amid count", BITS'(count), 0);
    cmp("amid full", BITS'(full), 0);
    for (int i = 0; i < DIM; i++) cmp($sformatf("amid q[%0d]", i), q[i], '0);
`ifdef FIFO_C_OVF_EN
    cmp("amid ovf", BITS'(ovf), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, BITS'(7), 1'b0);
    cmp("post rst q0", q[0], BITS'(7));
    cmp("post rst count", BITS'(count), 1);
    for (int i = 1; i < DIM; i++) drive(1'b1, BITS'(7 + i), 1'b0);
    drive(1'b0, '0, 1'b1);

    // Sparse en with RdEn during EMPTY/FILL
    drive(1'b0, '0, 1'b1);
    cmp("rd empty count", BITS'(count), 0);
    for (int i = 1; i <= DIM; i++) begin
      drive(1'b1, BITS'(200 + i), 1'b1 & (i != DIM));
      drive(1'b0, BITS'(999), 1'b1 & (i != DIM));
      cmp("sparse count", BITS'(count), BITS'(i));
    end
    cmp("sparse full", BITS'(full), 1);
    check_row_lit("sparse", 201);
    drive(1'b0, '0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic e, r;
      e = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 30);
      drive(e, {$urandom, $urandom}, r);
    end
    idle();

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_c.md
FIFO_C -- requirements
Module: fifo_c

Interface
REQ-001 Parameter DIM, default 8: number of words collected per row.
REQ-002 Parameter BITS, default 64: word width.
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  strobe: d carries one valid serial word this cycle.
REQ-006 d  input  BITS  serial word from the array edge.
REQ-007 RdEn  input  1  consumer pops the completed row.
REQ-008 q  output  [BITS-1:0] x [DIM-1:0]  parallel row; q[0] = first word received.
REQ-009 full  output  1  row complete; q valid.
REQ-010 count  output  $clog2(DIM+1)  words currently held.
REQ-011 ovf  output  1  sticky overflow flag; present only with FIFO_C_OVF_EN.

Function
REQ-012 States: EMPTY (count=0), FILL (0<count<DIM), FULL (count=DIM); full=1 only in FULL.
REQ-013 en in EMPTY/FILL: d written to q[count] on the next edge, count+1; the DIM-th word moves state to FULL on that same edge.
REQ-014 en=0: no state change; q entries hold.
REQ-015 RdEn in FULL without en: next edge count=0, state EMPTY; q entries retain stale data.
REQ-016 RdEn and en together in FULL: row released, d written to q[0], count=1, state FILL.
REQ-017 en in FULL without RdEn: word dropped, q unchanged; overflow event.
REQ-018 RdEn outside FULL: ignored.
REQ-019 q is combinational from storage registers; capture-to-visible latency 1 cycle; full rises the cycle after the DIM-th en.
REQ-020 q contents are defined only while full=1; entries above count are don't-care to the consumer.
REQ-021 count never exceeds DIM; no wrap-around.

Reset
REQ-022 rst_n low asynchronously forces state EMPTY, count=0, full=0, all q entries 0, ovf=0.
REQ-023 Reset mid-fill discards the partial row; first en after release writes q[0].

Configuration
REQ-024 Macro FIFO_C_OVF_EN defined: ovf port exists; set on any REQ-017 event; held until reset; RdEn does not clear it.
REQ-025 FIFO_C_OVF_EN undefined: no ovf port or register; overflow words silently dropped.

Structure
REQ-026 Package systolic_pkg holds DIM/BITS default constants and the state enum (EMPTY, FILL, FULL); fifo_c imports it.
REQ-027 Single module, no sub-modules; count width derived as $clog2(DIM+1).

Verification
REQ-028 Reset, then en for 8 cycles with d=1..8 -> full=1 the cycle after the 8th word, count=8, q[0]=1 ... q[7]=8.
REQ-029 Full row, RdEn=1 one cycle -> next cycle full=0, count=0; q[0..7] still 1..8.
REQ-030 Full row, RdEn=1 and en=1 with d=99 -> count=1, state FILL, q[0]=99, full=0.
REQ-031 Full row, en=1 d=55 with RdEn=0 -> q unchanged, count=8; ovf=1 with FIFO_C_OVF_EN, stays 1 after RdEn.
REQ-032 Write 3 words, assert rst_n low mid-cycle -> count=0, full=0, all q=0 immediately; next en d=7 -> q[0]=7, count=1.
REQ-033 en pulsed every other cycle, 8 words, RdEn in EMPTY/FILL -> idle cycles change nothing; RdEn ignored; full after 8th word.
